// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux, load byte/halfword extraction,
// misaligned-load detection and a retired-instruction counter.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             RegWrite_in,
  input  logic [1:0]       wb_sel_in,
  input  logic [2:0]       load_type_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [XLEN-1:0]  mem_data_in,
  input  logic [XLEN-1:0]  pc_plus4_in,
  input  logic [4:0]       rd_in,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             load_misalign,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_LINK = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_type_e;

  logic            valid;
  logic            reg_write;
  wb_sel_e         wb_sel;
  load_type_e      load_type;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] mem_data;
  logic [XLEN-1:0] pc_plus4;
  logic [4:0]      rd;

  logic            retire;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  // A held (stalled) instruction counts only on the cycle it actually leaves.
  assign retire = valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      reg_write  <= 1'b0;
      wb_sel     <= SEL_ALU;
      load_type  <= LD_B;
      alu_result <= '0;
      mem_data   <= '0;
      pc_plus4   <= '0;
      rd         <= '0;
      retired    <= '0;
    end else begin
      if (retire)
        retired <= retired + CNT_W'(1);
      if (flush) begin
        valid     <= 1'b0;
        reg_write <= 1'b0;
      end else if (!stall) begin
        valid      <= in_valid;
        reg_write  <= RegWrite_in;
        wb_sel     <= wb_sel_e'(wb_sel_in);
        load_type  <= load_type_e'(load_type_in);
        alu_result <= alu_result_in;
        mem_data   <= mem_data_in;
        pc_plus4   <= pc_plus4_in;
        rd         <= rd_in;
      end
    end
  end

  always_comb begin
    ld_byte = mem_data[7:0];
    case (alu_result[1:0])
      2'd1:    ld_byte = mem_data[15:8];
      2'd2:    ld_byte = mem_data[23:16];
      2'd3:    ld_byte = mem_data[31:24];
      default: ld_byte = mem_data[7:0];
    endcase
    ld_half = alu_result[1] ? mem_data[31:16] : mem_data[15:0];

    load_data = mem_data;
    case (load_type)
      LD_B:    load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      LD_BU:   load_data = {{(XLEN-8){1'b0}}, ld_byte};
      LD_H:    load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      LD_HU:   load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = mem_data;
    endcase
  end

  always_comb begin
    load_misalign = 1'b0;
    if (valid && wb_sel == SEL_LOAD) begin
      case (load_type)
        LD_B, LD_BU: load_misalign = 1'b0;
        LD_H, LD_HU: load_misalign = alu_result[0];
        default:     load_misalign = (alu_result[1:0] != 2'b00);
      endcase
    end

    case (wb_sel)
      SEL_LOAD: wb_data = load_data;
      SEL_LINK: wb_data = pc_plus4;
      default:  wb_data = alu_result;
    endcase
  end

  assign wb_valid = valid;
  assign wb_rd    = rd;
  assign wb_we    = valid & reg_write & (rd != 5'd0) & ~load_misalign;

endmodule
